mult_pipe: RTL and testbench

//  Pipelined RV32M multiplier FU for the execute stage: MUL/MULH/MULHSU/MULHU over NUM_STAGES cycles.

---
 rtl/mult_pipe_pkg.sv | 51 +++++
 rtl/mult_pipe_if.sv | 36 +++
 rtl/mult_pipe_stage.sv | 46 ++++
 rtl/mult_pipe.sv | 101 ++++++++++
 tb/tb_mult_pipe.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pipe_pkg.sv
// ============================================================================
// Module  : mult_pipe_pkg
// Brief   : Shared types and constants for the pipelined RV32M multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pipe_pkg;

    localparam int unsigned C_XLEN  = 32;
    localparam int unsigned C_TAG_W = 6;
    localparam int unsigned C_ROB_W = 5;
    localparam int unsigned C_DW    = 2 * C_XLEN;

    localparam logic [C_XLEN-1:0] C_BAD_FUNC_RESULT = 32'hfacebeec;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'h00,
        ALU_SUB    = 5'h01,
        ALU_AND    = 5'h02,
        ALU_OR     = 5'h03,
        ALU_XOR    = 5'h04,
        ALU_SLT    = 5'h05,
        ALU_SLTU   = 5'h06,
        ALU_SLL    = 5'h07,
        ALU_SRL    = 5'h08,
        ALU_SRA    = 5'h09,
        ALU_MUL    = 5'h0a,
        ALU_MULH   = 5'h0b,
        ALU_MULHSU = 5'h0c,
        ALU_MULHU  = 5'h0d
    } ALU_FUNC;

    typedef struct packed {
        logic                valid;
        ALU_FUNC             func;
        logic [C_DW-1:0]     mcand;
        logic [C_DW-1:0]     mplier;
        logic [C_DW-1:0]     prod;
        logic [C_TAG_W-1:0]  tag;
        logic [C_ROB_W-1:0]  rob_idx;
    } MULT_PIPE_PACKET;

    function automatic logic [C_DW-1:0] extend_operand(input logic [C_XLEN-1:0] v,
                                                       input logic is_signed);
        return is_signed ? {{C_XLEN{v[C_XLEN-1]}}, v} : {{C_XLEN{1'b0}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_pipe_if.sv
// ============================================================================
// Module  : mult_pipe_if
// Brief   : Issue-side and CDB-side valid/ready bundle of the multiplier FU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_pipe_if;
    import mult_pipe_pkg::*;

    logic                in_valid;
    logic                in_ready;
    ALU_FUNC             in_func;
    logic [C_XLEN-1:0]   in_opa;
    logic [C_XLEN-1:0]   in_opb;
    logic [C_TAG_W-1:0]  in_tag;
    logic [C_ROB_W-1:0]  in_rob_idx;
    logic                out_valid;
    logic                out_ready;
    logic [C_XLEN-1:0]   out_result;
    logic [C_TAG_W-1:0]  out_tag;
    logic [C_ROB_W-1:0]  out_rob_idx;

    modport master (
        output in_valid, in_func, in_opa, in_opb, in_tag, in_rob_idx, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_rob_idx
    );

    modport slave (
        input  in_valid, in_func, in_opa, in_opb, in_tag, in_rob_idx, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_rob_idx
    );

endinterface

`default_nettype wire

// File: rtl/mult_pipe_stage.sv
// ============================================================================
// Module  : mult_pipe_stage
// Brief   : One CH-bit partial-product step of the multiplier plus its register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_pipe_stage
    import mult_pipe_pkg::*;
#(
    parameter int unsigned CH = 16
) (
    input  wire logic       clock,
    input  wire logic       reset_n,
    input  wire logic       flush,
    input  wire logic       i_load,
    input  MULT_PIPE_PACKET i_pkt,
    output MULT_PIPE_PACKET o_pkt
);

    MULT_PIPE_PACKET w_next;
    MULT_PIPE_PACKET r_pkt;

    // Consume the low CH multiplier bits; the operands shift so the next stage sees the next chunk.
    always_comb begin
        w_next        = i_pkt;
        w_next.prod   = i_pkt.prod + i_pkt.mcand * C_DW'(i_pkt.mplier[CH-1:0]);
        w_next.mcand  = i_pkt.mcand << CH;
        w_next.mplier = i_pkt.mplier >> CH;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt <= '0;
        end else if (flush) begin
            r_pkt.valid <= 1'b0;
        end else if (i_load) begin
            r_pkt <= w_next;
        end
    end

    assign o_pkt = r_pkt;

endmodule

`default_nettype wire

// File: rtl/mult_pipe.sv
// ============================================================================
// Module  : mult_pipe
// Brief   : Pipelined RV32M MUL/MULH/MULHSU/MULHU unit with bubble-collapsing flow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = C_XLEN,
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned TAG_W      = C_TAG_W,
    parameter int unsigned ROB_W      = C_ROB_W
) (
    input  wire logic  clock,
    input  wire logic  reset_n,
    input  wire logic  flush,
    mult_pipe_if.slave bus
);

    localparam int unsigned C_NS_SAFE = (NUM_STAGES == 0) ? 1 : NUM_STAGES;
    localparam int unsigned C_CH      = (2 * XLEN) / C_NS_SAFE;

    if (NUM_STAGES < 1 || NUM_STAGES > 8 || ((2 * XLEN) % C_NS_SAFE) != 0 ||
        XLEN != C_XLEN || TAG_W != C_TAG_W || ROB_W != C_ROB_W) begin : g_bad_cfg
        $error("mult_pipe: illegal configuration XLEN=%0d NUM_STAGES=%0d", XLEN, NUM_STAGES);
    end

    MULT_PIPE_PACKET         w_head;
    MULT_PIPE_PACKET         w_pkt [1:NUM_STAGES];
    MULT_PIPE_PACKET         w_tail;
    logic [NUM_STAGES-1:0]   w_valid;
    logic [NUM_STAGES:0]     w_ready;
    logic                    w_unused_tail;

    // MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    always_comb begin
        w_head         = '0;
        w_head.valid   = bus.in_valid;
        w_head.func    = bus.in_func;
        w_head.mcand   = extend_operand(bus.in_opa,
                             (bus.in_func == ALU_MULH) || (bus.in_func == ALU_MULHSU));
        w_head.mplier  = extend_operand(bus.in_opb, bus.in_func == ALU_MULH);
        w_head.tag     = bus.in_tag;
        w_head.rob_idx = bus.in_rob_idx;
    end

    // A stage may load whenever it is empty or its content moves on; this collapses bubbles.
    always_comb begin
        w_ready             = '0;
        w_ready[NUM_STAGES] = bus.out_ready;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            w_ready[k] = !w_valid[k] || w_ready[k+1];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        MULT_PIPE_PACKET w_in;
        if (k == 0) begin : g_head
            assign w_in = w_head;
        end else begin : g_body
            assign w_in = w_pkt[k];
        end

        mult_pipe_stage #(
            .CH      (C_CH)
        ) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .flush   (flush),
            .i_load  (w_ready[k]),
            .i_pkt   (w_in),
            .o_pkt   (w_pkt[k+1])
        );

        assign w_valid[k] = w_pkt[k+1].valid;
    end

    assign w_tail          = w_pkt[NUM_STAGES];
    assign w_unused_tail   = ^{w_tail.mcand, w_tail.mplier};

    assign bus.in_ready    = w_ready[0];
    assign bus.out_valid   = w_tail.valid;
    assign bus.out_tag     = w_tail.tag;
    assign bus.out_rob_idx = w_tail.rob_idx;

    always_comb begin
        bus.out_result = '0;
        if (w_tail.valid) begin
            case (w_tail.func)
                ALU_MUL:                          bus.out_result = w_tail.prod[XLEN-1:0];
                ALU_MULH, ALU_MULHSU, ALU_MULHU:  bus.out_result = w_tail.prod[2*XLEN-1:XLEN];
                default:                          bus.out_result = C_BAD_FUNC_RESULT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_pipe.sv
// ============================================================================
// Module  : tb_mult_pipe
// Brief   : Self-checking bench for mult_pipe: directed corner ops plus random traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_pipe;
    import mult_pipe_pkg::*;

    parameter int NS = 4;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
        logic [4:0]  rob;
    } exp_t;

    logic clk;
    logic reset_n;
    logic flush;
    int   n_checks;
    int   n_err;
    int   n_out;
    exp_t q[$];

    mult_pipe_if bus ();

    mult_pipe #(
        .NUM_STAGES (NS)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: full-width products computed with native 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input ALU_FUNC f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            ALU_MUL:    begin p = ua * ub;           return p[31:0];  end
            ALU_MULH:   begin p = sa * sb;           return p[63:32]; end
            ALU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub;           return p[63:32]; end
            default:    return 32'hfacebeec;
        endcase
    endfunction

    // Scoreboard: in-flight ops in issue order; every cycle checks in_ready and each result.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
        end else begin
            check("in_ready", bus.in_ready == ((q.size() < NS) || bus.out_ready),
                  64'(bus.in_ready), 64'((q.size() < NS) || bus.out_ready));
            if (bus.out_valid)
                check("out_valid_no_op_in_flight", q.size() > 0, 64'(bus.out_valid), 64'(0));
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_out++;
                check("out_result", bus.out_result == e.res, 64'(bus.out_result), 64'(e.res));
                check("out_tag", bus.out_tag == e.tag, 64'(bus.out_tag), 64'(e.tag));
                check("out_rob_idx", bus.out_rob_idx == e.rob, 64'(bus.out_rob_idx), 64'(e.rob));
            end
            if (flush) begin
                q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                q.push_back('{res: ref_mul(bus.in_func, bus.in_opa, bus.in_opb),
                              tag: bus.in_tag, rob: bus.in_rob_idx});
            end
        end
    end

    task automatic drive_cycle(input logic v, input ALU_FUNC f, input logic [31:0] a,
                               input logic [31:0] b, input logic [5:0] t, input logic [4:0] r,
                               input logic fl, input logic ordy, output logic acc);
        @(posedge clk);
        #1;
        bus.in_valid   = v;
        bus.in_func    = f;
        bus.in_opa     = a;
        bus.in_opb     = b;
        bus.in_tag     = t;
        bus.in_rob_idx = r;
        bus.out_ready  = ordy;
        flush          = fl;
        @(negedge clk);
        #1;
        acc = v && bus.in_ready && !fl;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++)
            drive_cycle(1'b0, ALU_ADD, 32'h0, 32'h0, 6'h0, 5'h0, 1'b0, 1'b1, acc);
    endtask

    task automatic single_op(input string name, input ALU_FUNC f, input logic [31:0] a,
                             input logic [31:0] b, input logic [5:0] t, input logic [31:0] exp_res);
        logic acc;
        int   lat;
        drive_cycle(1'b1, f, a, b, t, 5'd3, 1'b0, 1'b1, acc);
        check({name, "_accept"}, acc, 64'(acc), 64'(1));
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < NS + 4);
        check({name, "_latency"}, lat == NS, 64'(lat), 64'(NS));
        check({name, "_result"}, bus.out_result == exp_res, 64'(bus.out_result), 64'(exp_res));
        check({name, "_tag"}, bus.out_tag == t, 64'(bus.out_tag), 64'(t));
        idle(1);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'h7fff_ffff;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    function automatic ALU_FUNC rand_func();
        if ($urandom_range(0, 9) < 8) return ALU_FUNC'(5'(10 + $urandom_range(0, 3)));
        return ALU_FUNC'(5'($urandom_range(0, 31)));
    endfunction

    initial begin
        logic acc;
        int   idx, cyc, base, n_acc;

        n_checks = 0; n_err = 0; n_out = 0;
        reset_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_func = ALU_ADD; bus.in_opa = '0; bus.in_opb = '0;
        bus.in_tag = '0; bus.in_rob_idx = '0; bus.out_ready = 1'b1;

        // The reference model itself, pinned on hand-computed values.
        check("model_mulhsu", ref_mul(ALU_MULHSU, 32'hffffffff, 32'hffffffff) == 32'hffffffff,
              64'(ref_mul(ALU_MULHSU, 32'hffffffff, 32'hffffffff)), 64'hffffffff);
        check("model_mulhu", ref_mul(ALU_MULHU, 32'hffffffff, 32'hffffffff) == 32'hfffffffe,
              64'(ref_mul(ALU_MULHU, 32'hffffffff, 32'hffffffff)), 64'hfffffffe);

        repeat (3) @(negedge clk);
        check("reset_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'(0));
        check("reset_in_ready", bus.in_ready == 1'b1, 64'(bus.in_ready), 64'(1));
        check("reset_out_result", bus.out_result == '0, 64'(bus.out_result), 64'(0));
        check("reset_out_tag", bus.out_tag == '0, 64'(bus.out_tag), 64'(0));
        check("reset_out_rob_idx", bus.out_rob_idx == '0, 64'(bus.out_rob_idx), 64'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;

        single_op("mul_7x6", ALU_MUL, 32'd7, 32'd6, 6'd5, 32'd42);
        single_op("mulh_m1", ALU_MULH, 32'hffffffff, 32'hffffffff, 6'd1, 32'h00000000);
        single_op("mulhu_max", ALU_MULHU, 32'hffffffff, 32'hffffffff, 6'd2, 32'hfffffffe);
        single_op("mulhsu_m1", ALU_MULHSU, 32'hffffffff, 32'hffffffff, 6'd3, 32'hffffffff);
        single_op("mulh_min", ALU_MULH, 32'h80000000, 32'h80000000, 6'd4, 32'h40000000);
        single_op("mul_wrap", ALU_MUL, 32'hffffffff, 32'd2, 6'd6, 32'hfffffffe);
        single_op("bad_func", ALU_ADD, 32'd3, 32'd4, 6'd7, 32'hfacebeec);

        // Back-pressure: six ops against a stalled CDB, then release and drain in order.
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            drive_cycle(idx < 6, rand_func(), rand_op(), rand_op(), 6'(idx + 10), 5'(idx),
                        1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("stall_accepts", idx == ((NS < 6) ? NS : 6), 64'(idx), 64'((NS < 6) ? NS : 6));
        base = n_out;
        cyc  = 0;
        while (n_out < base + 6 && cyc < 30) begin
            drive_cycle(idx < 6, rand_func(), rand_op(), rand_op(), 6'(idx + 10), 5'(idx),
                        1'b0, 1'b1, acc);
            if (acc) idx++;
            cyc++;
        end
        check("stall_drain_count", n_out == base + 6, 64'(n_out - base), 64'(6));
        check("stall_drain_cycles", cyc == 6, 64'(cyc), 64'(6));

        // Flush on the third issue cycle; nothing may appear afterwards.
        drive_cycle(1'b1, ALU_MUL, 32'd11, 32'd13, 6'd20, 5'd20, 1'b0, 1'b1, acc);
        drive_cycle(1'b1, ALU_MULHU, 32'd12, 32'd14, 6'd21, 5'd21, 1'b0, 1'b1, acc);
        drive_cycle(1'b1, ALU_MULH, 32'd15, 32'd16, 6'd22, 5'd22, 1'b1, 1'b1, acc);
        check("flush_cycle_accept", acc == 1'b0, 64'(acc), 64'(0));
        for (int c = 0; c < NS + 3; c++) begin
            drive_cycle(1'b0, ALU_ADD, 32'h0, 32'h0, 6'h0, 5'h0, 1'b0, 1'b1, acc);
            check("flush_no_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'(0));
        end
        single_op("after_flush", ALU_MUL, 32'd100, 32'd200, 6'd9, 32'd20000);

        // Asynchronous reset with ops in flight.
        drive_cycle(1'b1, ALU_MUL, 32'd5, 32'd5, 6'd30, 5'd30, 1'b0, 1'b0, acc);
        drive_cycle(1'b1, ALU_MUL, 32'd6, 32'd6, 6'd31, 5'd31, 1'b0, 1'b0, acc);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_out_valid", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'(0));
        check("async_reset_in_ready", bus.in_ready == 1'b1, 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        for (int c = 0; c < NS + 2; c++) begin
            drive_cycle(1'b0, ALU_ADD, 32'h0, 32'h0, 6'h0, 5'h0, 1'b0, 1'b1, acc);
            check("post_reset_no_stale", bus.out_valid == 1'b0, 64'(bus.out_valid), 64'(0));
        end
        single_op("after_reset", ALU_MULHU, 32'h80000000, 32'h4, 6'd33, 32'h2);

        // Random traffic against the scoreboard.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            drive_cycle($urandom_range(0, 9) < 7, rand_func(), rand_op(), rand_op(),
                        6'($urandom), 5'($urandom), $urandom_range(0, 99) == 0,
                        $urandom_range(0, 9) < 7, acc);
            if (acc) n_acc++;
            cyc++;
        end
        check("random_op_count", n_acc >= 10000, 64'(n_acc), 64'(10000));
        idle(NS + 2);
        check("random_drained", q.size() == 0, 64'(q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
